// File: rtl/tnoc_vc_link_scheduler.sv
// Credit-based round-robin flit scheduler for one NoC link shared by several virtual channels.
// One flit per cycle is accepted from an eligible VC and launched on a registered link output.
package tnoc_vc_link_scheduler_pkg;
    typedef struct packed {
        int virtual_channels;
        int data_width;
        int input_fifo_depth;
    } tnoc_config;

    localparam tnoc_config TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        data_width:       256,
        input_fifo_depth: 8
    };
endpackage

module tnoc_vc_link_scheduler
    import tnoc_vc_link_scheduler_pkg::*;
#(
    parameter tnoc_config CONFIG = TNOC_DEFAULT_CONFIG
)(
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic [CONFIG.virtual_channels-1:0]                        i_valid,
    output logic [CONFIG.virtual_channels-1:0]                        i_ready,
    input  logic [CONFIG.virtual_channels*CONFIG.data_width-1:0]      i_data,
    input  logic [CONFIG.virtual_channels-1:0]                        i_last,
    input  logic [CONFIG.virtual_channels-1:0]                        i_credit_return,
    output logic                                                      o_valid,
    output logic [CONFIG.virtual_channels-1:0]                        o_vc,
    output logic [CONFIG.data_width-1:0]                              o_data,
    output logic                                                      o_last,
    output logic [CONFIG.virtual_channels-1:0]                        o_credit_empty
);
    localparam int VC = CONFIG.virtual_channels;
    localparam int W  = CONFIG.data_width;
    localparam int CW = $clog2(CONFIG.input_fifo_depth + 1);
    localparam int PW = (VC > 1) ? $clog2(VC) : 1;
    localparam logic [CW-1:0] DEPTH    = CW'(CONFIG.input_fifo_depth);
    localparam logic [PW:0]   VC_COUNT = (PW + 1)'(VC);

    logic [VC-1:0] credit_zero;
    logic [VC-1:0] eligible;
    logic [VC-1:0] rotated;
    logic [VC-1:0] grant;
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] offset;
    logic [PW-1:0] sel_idx;
    logic [PW:0]   sel_sum;
    logic [PW:0]   ptr_sum;
    logic          found;
    logic [W-1:0]  data_arr [VC];

    logic          valid_reg;
    logic [VC-1:0] vc_reg;
    logic [W-1:0]  data_reg;
    logic          last_reg;

    // Rotate eligibility so that bit 0 is the VC at the pointer; the lowest set bit wins.
    always_comb begin
        rotated  = VC'({eligible, eligible} >> ptr_reg);
        offset   = '0;
        found    = 1'b0;
        for (int k = 0; k < VC; k++) begin
            if (!found && rotated[k]) begin
                found  = 1'b1;
                offset = PW'(k);
            end
        end
        sel_sum = {1'b0, ptr_reg} + {1'b0, offset};
        if (sel_sum >= VC_COUNT) begin
            sel_sum = sel_sum - VC_COUNT;
        end
        sel_idx = sel_sum[PW-1:0];
        ptr_sum = {1'b0, sel_idx} + (PW + 1)'(1);
        if (ptr_sum >= VC_COUNT) begin
            ptr_sum = '0;
        end
        ptr_next = ptr_sum[PW-1:0];
        grant    = '0;
        if (found && !rst) begin
            grant[sel_idx] = 1'b1;
        end
    end

    assign i_ready = grant;

    generate
        for (genvar gi = 0; gi < VC; gi++) begin : g_vc
            logic [CW-1:0] credit_reg;
            logic [CW-1:0] credit_next;
            logic          credit_empty_reg;

            assign data_arr[gi]       = i_data[gi*W +: W];
            assign credit_zero[gi]    = (credit_reg == '0);
            assign eligible[gi]       = i_valid[gi] & ~credit_zero[gi];
            assign o_credit_empty[gi] = credit_empty_reg;

            // A grant and a return in the same cycle cancel; a return at full credit saturates.
            always_comb begin
                credit_next = credit_reg;
                if (grant[gi] && !i_credit_return[gi]) begin
                    credit_next = credit_reg - CW'(1);
                end else if (!grant[gi] && i_credit_return[gi] && credit_reg != DEPTH) begin
                    credit_next = credit_reg + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    credit_reg       <= DEPTH;
                    credit_empty_reg <= 1'b0;
                end else begin
                    credit_reg       <= credit_next;
                    credit_empty_reg <= (credit_next == '0);
                end
            end

            credit_overflow_check: assert property (
                @(posedge clk) disable iff (rst)
                !(i_credit_return[gi] && credit_reg == DEPTH)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (|grant) begin
            ptr_reg <= ptr_next;
        end
    end

    // Idle cycles clear the whole link word so the wire is quiet.
    always_ff @(posedge clk) begin
        if (rst || !(|grant)) begin
            valid_reg <= 1'b0;
            vc_reg    <= '0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b1;
            vc_reg    <= grant;
            data_reg  <= data_arr[sel_idx];
            last_reg  <= i_last[sel_idx];
        end
    end

    assign o_valid = valid_reg;
    assign o_vc    = vc_reg;
    assign o_data  = data_reg;
    assign o_last  = last_reg;

endmodule

// File: tb/tb_tnoc_vc_link_scheduler.sv
// Self-checking bench for tnoc_vc_link_scheduler: directed scenarios plus randomized traffic
// compared each cycle against a credit/round-robin reference model.
module tb_tnoc_vc_link_scheduler;
    import tnoc_vc_link_scheduler_pkg::*;

    localparam tnoc_config CFG = TNOC_DEFAULT_CONFIG;
    localparam int VC    = CFG.virtual_channels;
    localparam int W     = CFG.data_width;
    localparam int DEPTH = CFG.input_fifo_depth;

    logic            clk = 1'b0;
    logic            rst;
    logic [VC-1:0]   i_valid;
    logic [VC-1:0]   i_ready;
    logic [VC*W-1:0] i_data;
    logic [VC-1:0]   i_last;
    logic [VC-1:0]   i_credit_return;
    logic            o_valid;
    logic [VC-1:0]   o_vc;
    logic [W-1:0]    o_data;
    logic            o_last;
    logic [VC-1:0]   o_credit_empty;

    tnoc_vc_link_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_ready         (i_ready),
        .i_data          (i_data),
        .i_last          (i_last),
        .i_credit_return (i_credit_return),
        .o_valid         (o_valid),
        .o_vc            (o_vc),
        .o_data          (o_data),
        .o_last          (o_last),
        .o_credit_empty  (o_credit_empty)
    );

    always #5 clk = ~clk;

    // Reference model state
    int            cred [VC];
    int            ptr;
    logic          exp_valid;
    logic [VC-1:0] exp_vc;
    logic [W-1:0]  exp_data;
    logic          exp_last;
    logic [VC-1:0] exp_empty;
    int            last_grant;
    logic [VC-1:0] obs_ready;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cnt [VC];
    int n_out;

    logic [W-1:0] pkt_data [VC][$];
    logic         pkt_last [VC][$];
    logic [W-1:0] link_seq [5];
    logic         link_last_seq [5];

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int i = 0; i < W/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic new_flit(input int v);
        i_data[v*W +: W] = rand_data();
        i_last[v]        = 1'($urandom_range(0, 1));
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic run_cycle();
        int g;
        logic [VC-1:0] exp_ready;
        g = -1;
        exp_ready = '0;
        #1;
        if (!rst) begin
            for (int k = 0; k < VC; k++) begin
                int v;
                v = (ptr + k) % VC;
                if (g < 0 && i_valid[v] && cred[v] > 0) g = v;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = i_ready;
        check_value("i_ready", W'(i_ready), W'(exp_ready));
        @(posedge clk);
        if (rst) begin
            for (int v = 0; v < VC; v++) cred[v] = DEPTH;
            ptr       = 0;
            exp_valid = 1'b0;
            exp_vc    = '0;
            exp_data  = '0;
            exp_last  = 1'b0;
            exp_empty = '0;
        end else begin
            for (int v = 0; v < VC; v++) begin
                cred[v] = cred[v] + (i_credit_return[v] ? 1 : 0) - (g == v ? 1 : 0);
                if (cred[v] > DEPTH) cred[v] = DEPTH;
                exp_empty[v] = (cred[v] == 0);
            end
            if (g >= 0) begin
                ptr       = (g + 1) % VC;
                exp_valid = 1'b1;
                exp_vc    = '0;
                exp_vc[g] = 1'b1;
                exp_data  = i_data[g*W +: W];
                exp_last  = i_last[g];
            end else begin
                exp_valid = 1'b0;
                exp_vc    = '0;
                exp_data  = '0;
                exp_last  = 1'b0;
            end
        end
        last_grant = g;
        @(negedge clk);
        check_value("o_valid", W'(o_valid), W'(exp_valid));
        check_value("o_vc", W'(o_vc), W'(exp_vc));
        check_value("o_data", o_data, exp_data);
        check_value("o_last", W'(o_last), W'(exp_last));
        check_value("o_credit_empty", W'(o_credit_empty), W'(exp_empty));
        $display("cyc t=%0t rst=%0b valid=%b ready=%b ret=%b o_valid=%0b o_vc=%b o_last=%0b empty=%b",
                 $time, rst, i_valid, obs_ready, i_credit_return, o_valid, o_vc, o_last, o_credit_empty);
    endtask

    initial begin
        rst             = 1'b1;
        i_valid         = '0;
        i_data          = '0;
        i_last          = '0;
        i_credit_return = '0;
        for (int v = 0; v < VC; v++) cred[v] = DEPTH;
        ptr = 0; exp_valid = 0; exp_vc = '0; exp_data = '0; exp_last = 0; exp_empty = '0;
        last_grant = -1;
        @(negedge clk);

        // Reset held with both VCs requesting
        i_valid = 2'b11;
        new_flit(0); new_flit(1);
        repeat (3) run_cycle();
        rst = 1'b0;

        // Round-robin with steady credit returns
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 10; c++) begin
            i_credit_return = '0;
            if (c > 0 && last_grant >= 0) i_credit_return[last_grant] = 1'b1;
            run_cycle();
            check_value("rr_order", W'(obs_ready), (c % 2 == 0) ? W'(2'b01) : W'(2'b10));
            for (int v = 0; v < VC; v++) if (obs_ready[v]) begin cnt[v]++; new_flit(v); end
        end
        check_value("rr_count_vc0", W'(cnt[0]), W'(5));
        check_value("rr_count_vc1", W'(cnt[1]), W'(5));
        i_valid = '0;
        i_credit_return = 2'b10;
        run_cycle();

        // Credit exhaustion on VC1
        i_credit_return = '0;
        i_valid = 2'b10;
        cnt[1] = 0;
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            if (obs_ready[1]) begin cnt[1]++; new_flit(1); end
        end
        check_value("exhaust_accepts", W'(cnt[1]), W'(8));
        check_value("exhaust_empty", W'(o_credit_empty), W'(2'b10));
        i_credit_return = 2'b10;
        run_cycle();
        check_value("return_no_grant", W'(obs_ready), W'(0));
        check_value("return_empty_clear", W'(o_credit_empty), W'(0));
        i_credit_return = '0;
        run_cycle();
        check_value("return_grant_next", W'(obs_ready), W'(2'b10));
        i_valid = '0;
        i_credit_return = 2'b10;
        repeat (8) run_cycle();

        // Simultaneous grant and return on VC0
        i_credit_return = '0;
        i_valid = 2'b01;
        repeat (5) begin run_cycle(); new_flit(0); end
        i_credit_return = 2'b01;
        run_cycle();
        check_value("sim_grant", W'(obs_ready), W'(2'b01));
        new_flit(0);
        i_credit_return = '0;
        cnt[0] = 0;
        repeat (5) begin
            run_cycle();
            if (obs_ready[0]) begin cnt[0]++; new_flit(0); end
        end
        check_value("sim_credit_kept", W'(cnt[0]), W'(3));
        i_credit_return = 2'b01;
        run_cycle();
        check_value("zero_ret_no_grant", W'(obs_ready), W'(0));
        i_credit_return = '0;
        run_cycle();
        check_value("zero_ret_next_grant", W'(obs_ready), W'(2'b01));
        i_valid = '0;
        i_credit_return = 2'b01;
        repeat (8) run_cycle();

        // Interleaved packets after a reset pulse
        i_credit_return = '0;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        pkt_data[0] = '{W'('hA0), W'('hA1), W'('hA2)};
        pkt_last[0] = '{1'b0, 1'b0, 1'b1};
        pkt_data[1] = '{W'('hB0), W'('hB1)};
        pkt_last[1] = '{1'b0, 1'b1};
        link_seq      = '{W'('hA0), W'('hB0), W'('hA1), W'('hB1), W'('hA2)};
        link_last_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        n_out = 0;
        for (int c = 0; c < 7; c++) begin
            for (int v = 0; v < VC; v++) begin
                i_valid[v] = (pkt_data[v].size() > 0);
                if (i_valid[v]) begin
                    i_data[v*W +: W] = pkt_data[v][0];
                    i_last[v]        = pkt_last[v][0];
                end
            end
            run_cycle();
            for (int v = 0; v < VC; v++) if (obs_ready[v] && pkt_data[v].size() > 0) begin
                void'(pkt_data[v].pop_front());
                void'(pkt_last[v].pop_front());
            end
            if (o_valid && n_out < 5) begin
                check_value("link_order", o_data, link_seq[n_out]);
                check_value("link_last", W'(o_last), W'(link_last_seq[n_out]));
                n_out++;
            end
        end
        check_value("link_count", W'(n_out), W'(5));
        i_valid = '0;
        i_credit_return = 2'b11;
        repeat (2) run_cycle();
        i_credit_return = 2'b01;
        run_cycle();

        // Reset in the middle of a 4-flit packet on VC0
        i_credit_return = '0;
        i_valid = 2'b01;
        new_flit(0);
        repeat (2) begin run_cycle(); new_flit(0); end
        rst = 1'b1;
        run_cycle();
        check_value("midrst_o_valid", W'(o_valid), W'(0));
        rst = 1'b0;
        i_valid = 2'b11;
        new_flit(1);
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 17; c++) begin
            run_cycle();
            if (c == 0) check_value("midrst_ptr", W'(obs_ready), W'(2'b01));
            for (int v = 0; v < VC; v++) if (obs_ready[v]) begin cnt[v]++; new_flit(v); end
        end
        check_value("midrst_credit_vc0", W'(cnt[0]), W'(8));
        check_value("midrst_credit_vc1", W'(cnt[1]), W'(8));
        i_valid = '0;
        i_credit_return = 2'b11;
        repeat (8) run_cycle();

        // Randomized traffic with occasional reset
        i_credit_return = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int v = 0; v < VC; v++) begin
                if (!i_valid[v] && $urandom_range(0, 2) != 0) begin
                    i_valid[v] = 1'b1;
                    new_flit(v);
                end
                i_credit_return[v] = (cred[v] < DEPTH) && ($urandom_range(0, 2) == 0);
            end
            run_cycle();
            for (int v = 0; v < VC; v++) if (obs_ready[v]) i_valid[v] = 1'b0;
        end
        rst = 1'b0;
        i_valid = '0;
        i_credit_return = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
